text_sequencer: RTL

TEXT_SEQUENCER -- requirements
Module: text_sequencer

---
 rtl/text_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/text_sequencer.sv
// rtl/text_sequencer.sv - character buffer that replays stored text as a stream of font columns
//
// Purpose: stores up to WORD_COUNT 6-bit character codes written in IDLE and,
// while play is high, emits every stored character as COLS_PER_CHAR columns
// (char_code/col_idx for a font ROM), followed by GAP_COLS blank columns per frame.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   wr_en       in   write strobe for wr_char (honoured only in IDLE)
//   wr_char     in   [6]=1 CLEAR command, else [5:0] is a character code
//   play        in   playback enable (level)
//   char_code   out  character code of the current column
//   col_idx     out  column within the character
//   col_valid   out  char_code/col_idx describe a real column
//   frame_start out  pulse on the first column of each frame
//   buf_count   out  number of stored characters
//   full        out  buf_count == WORD_COUNT
//   overflow    out  sticky: a write was dropped because the buffer was full
module text_sequencer #(
  parameter int WORD_COUNT    = 32,
  parameter int COLS_PER_CHAR = 8,
  parameter int GAP_COLS      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [6:0] wr_char,
  input  logic       play,
  output logic [5:0] char_code,
  output logic [2:0] col_idx,
  output logic       col_valid,
  output logic       frame_start,
  output logic [5:0] buf_count,
  output logic       full,
  output logic       overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int         PTR_W     = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [5:0] COUNT_MAX = 6'(WORD_COUNT);
  localparam logic [2:0] LAST_COL  = 3'(COLS_PER_CHAR - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_COLS - 1);

  logic [1:0]       state;
  logic [PTR_W-1:0] rd_ptr;
  logic [7:0]       gap_cnt;
  logic [5:0]       mem [WORD_COUNT];

  logic             store;
  logic             last_slot;
  logic [PTR_W-1:0] next_ptr;

  // A character is stored only in IDLE, for a non-CLEAR code, with room left.
  assign store     = (state == IDLE) && wr_en && !wr_char[6] && !full;
  assign next_ptr  = rd_ptr + PTR_W'(1);
  assign last_slot = (6'(rd_ptr) == (buf_count - 6'd1));

  // Buffer contents are deliberately not reset; buf_count=0 hides stale data.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[buf_count[PTR_W-1:0]] <= wr_char[5:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      gap_cnt     <= '0;
      buf_count   <= '0;
      full        <= 1'b0;
      overflow    <= 1'b0;
      char_code   <= '0;
      col_idx     <= '0;
      col_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          char_code <= '0;
          col_idx   <= '0;
          col_valid <= 1'b0;
          // A write always wins over starting playback in the same cycle.
          if (wr_en) begin
            if (wr_char[6]) begin
              buf_count <= '0;
              full      <= 1'b0;
              overflow  <= 1'b0;
            end else if (!full) begin
              buf_count <= buf_count + 6'd1;
              full      <= ((buf_count + 6'd1) == COUNT_MAX);
            end else begin
              overflow  <= 1'b1;
            end
          end else if (play && (buf_count != 6'd0)) begin
            state       <= SCAN;
            rd_ptr      <= '0;
            char_code   <= mem[0];
            col_idx     <= '0;
            col_valid   <= 1'b1;
            frame_start <= 1'b1;
          end
        end

        SCAN: begin
          if (col_idx != LAST_COL) begin
            col_idx <= col_idx + 3'd1;
          end else if (!play) begin
            // play dropped: the current character is complete, skip the gap.
            state     <= IDLE;
            rd_ptr    <= '0;
            char_code <= '0;
            col_idx   <= '0;
            col_valid <= 1'b0;
          end else if (last_slot) begin
            state     <= GAP;
            rd_ptr    <= '0;
            gap_cnt   <= GAP_LAST;
            char_code <= '0;
            col_idx   <= '0;
            col_valid <= 1'b0;
          end else begin
            rd_ptr    <= next_ptr;
            char_code <= mem[next_ptr];
            col_idx   <= '0;
          end
        end

        GAP: begin
          // gap_cnt counts down from GAP_COLS-1, so GAP lasts GAP_COLS cycles.
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (play) begin
            state       <= SCAN;
            rd_ptr      <= '0;
            char_code   <= mem[0];
            col_idx     <= '0;
            col_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          rd_ptr    <= '0;
          char_code <= '0;
          col_idx   <= '0;
          col_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
